// File: rtl/camera_capture_pack.sv
// DVP camera capture: packs DATA_W-bit samples into DDR words, with frame-synchronised start/stop,
// startup frame skip, end-of-line partial flush and geometry checks. Define CAPTURE_BYTE_SWAP_EN for LS-first packing.
module camera_capture_pack #(
    parameter int DATA_W         = 8,
    parameter int BYTES_PER_WORD = 4,
    parameter int H_BYTES        = 1280,
    parameter int V_LINES        = 720,
    parameter int SKIP_FRAMES    = 10
) (
    input  logic                               camera_pclk,
    input  logic                               rst,
    input  logic                               init_done,
    input  logic                               capture_en,
    input  logic                               camera_href,
    input  logic                               camera_vsync,
    input  logic [DATA_W-1:0]                  camera_data,
    output logic                               ddr_wren,
    output logic [DATA_W*BYTES_PER_WORD-1:0]   ddr_data_camera,
    output logic                               ddr_sof,
    output logic                               ddr_eol,
    output logic [15:0]                        frame_cnt,
    output logic                               line_err,
    output logic                               frame_err
);

    localparam int WORD_W = DATA_W * BYTES_PER_WORD;
    localparam int SLOT_W = $clog2(BYTES_PER_WORD);

    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(BYTES_PER_WORD - 1);
    localparam logic [15:0]       H_EXP     = 16'(H_BYTES);
    localparam logic [15:0]       V_EXP     = 16'(V_LINES);
    localparam logic [15:0]       SKIP_LAST = 16'(SKIP_FRAMES - 1);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_SKIP    = 2'd1;
    localparam logic [1:0] ST_ARM     = 2'd2;
    localparam logic [1:0] ST_CAPTURE = 2'd3;

    logic [1:0]        state_q,      state_d;
    logic              vsync_q,      vsync_d;
    logic              in_line_q,    in_line_d;
    logic              sof_pend_q,   sof_pend_d;
    logic [WORD_W-1:0] pack_q,       pack_d;
    logic [SLOT_W-1:0] slot_q,       slot_d;
    logic [15:0]       sample_cnt_q, sample_cnt_d;
    logic [15:0]       line_cnt_q,   line_cnt_d;
    logic [15:0]       skip_cnt_q,   skip_cnt_d;
    logic              wren_q,       wren_d;
    logic [WORD_W-1:0] data_q,       data_d;
    logic              sof_q,        sof_d;
    logic              eol_q,        eol_d;
    logic [15:0]       frame_cnt_q,  frame_cnt_d;
    logic              line_err_q,   line_err_d;
    logic              frame_err_q,  frame_err_d;

    logic              vsync_rise;
    logic              vsync_fall;
    logic              sample_valid;
    logic [WORD_W-1:0] word;
    logic [SLOT_W-1:0] lane;
    logic [15:0]       line_cnt_nxt;
    int unsigned       lane_base;

    assign vsync_rise   = camera_vsync & ~vsync_q;
    assign vsync_fall   = ~camera_vsync & vsync_q;
    assign sample_valid = camera_href & ~camera_vsync;

    always_comb begin
        // NOTE: every variable assigned here gets a default first, so no path leaves one unassigned and no latch is inferred.
        state_d      = state_q;
        vsync_d      = camera_vsync;
        in_line_d    = in_line_q;
        sof_pend_d   = sof_pend_q;
        pack_d       = pack_q;
        slot_d       = slot_q;
        sample_cnt_d = sample_cnt_q;
        line_cnt_d   = line_cnt_q;
        skip_cnt_d   = skip_cnt_q;
        wren_d       = 1'b0;
        data_d       = data_q;
        sof_d        = 1'b0;
        eol_d        = 1'b0;
        frame_cnt_d  = frame_cnt_q;
        line_err_d   = 1'b0;
        frame_err_d  = 1'b0;
        word         = pack_q;
        line_cnt_nxt = line_cnt_q;
`ifdef CAPTURE_BYTE_SWAP_EN
        lane         = slot_q;
`else
        lane         = LAST_SLOT - slot_q;
`endif
        lane_base    = int'(lane) * DATA_W;

        if (!init_done) begin
            // Losing sensor config abandons everything in flight: no flush, no pulses.
            state_d      = ST_IDLE;
            in_line_d    = 1'b0;
            sof_pend_d   = 1'b0;
            pack_d       = '0;
            slot_d       = '0;
            sample_cnt_d = '0;
            line_cnt_d   = '0;
            skip_cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    skip_cnt_d = '0;
                    if (SKIP_FRAMES > 0) state_d = ST_SKIP;
                    else                 state_d = ST_ARM;
                end
                ST_SKIP: begin
                    if (vsync_rise) begin
                        if (skip_cnt_q == SKIP_LAST) state_d = ST_ARM;
                        else                         skip_cnt_d = skip_cnt_q + 16'd1;
                    end
                end
                ST_ARM: begin
                    if (vsync_fall && capture_en) begin
                        state_d      = ST_CAPTURE;
                        sof_pend_d   = 1'b1;
                        in_line_d    = 1'b0;
                        pack_d       = '0;
                        slot_d       = '0;
                        sample_cnt_d = '0;
                        line_cnt_d   = '0;
                    end
                end
                default: begin
                    if (sample_valid) begin
                        in_line_d = 1'b1;
                        word[lane_base +: DATA_W] = camera_data;
                        if (sample_cnt_q != 16'hFFFF) sample_cnt_d = sample_cnt_q + 16'd1;
                        if (slot_q == LAST_SLOT) begin
                            wren_d     = 1'b1;
                            data_d     = word;
                            sof_d      = sof_pend_q;
                            sof_pend_d = 1'b0;
                            pack_d     = '0;
                            slot_d     = '0;
                        end else begin
                            pack_d = word;
                            slot_d = slot_q + SLOT_W'(1);
                        end
                    end else if (in_line_q) begin
                        // Line end: unfilled lanes of pack_q are already zero, so it flushes as-is.
                        eol_d        = 1'b1;
                        line_err_d   = (sample_cnt_q != H_EXP);
                        if (slot_q != '0) begin
                            wren_d     = 1'b1;
                            data_d     = pack_q;
                            sof_d      = sof_pend_q;
                            sof_pend_d = 1'b0;
                        end
                        in_line_d    = 1'b0;
                        pack_d       = '0;
                        slot_d       = '0;
                        sample_cnt_d = '0;
                        line_cnt_nxt = line_cnt_q + 16'd1;
                        line_cnt_d   = line_cnt_nxt;
                    end

                    if (vsync_rise) begin
                        frame_err_d = (line_cnt_nxt != V_EXP);
                        frame_cnt_d = frame_cnt_q + 16'd1;
                        line_cnt_d  = '0;
                        state_d     = ST_ARM;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge camera_pclk) begin
        // NOTE: sequential state is updated with non-blocking assignments only, so every flop sees pre-edge values.
        if (rst) begin
            state_q      <= ST_IDLE;
            vsync_q      <= 1'b0;
            in_line_q    <= 1'b0;
            sof_pend_q   <= 1'b0;
            pack_q       <= '0;
            slot_q       <= '0;
            sample_cnt_q <= '0;
            line_cnt_q   <= '0;
            skip_cnt_q   <= '0;
            wren_q       <= 1'b0;
            data_q       <= '0;
            sof_q        <= 1'b0;
            eol_q        <= 1'b0;
            frame_cnt_q  <= '0;
            line_err_q   <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            vsync_q      <= vsync_d;
            in_line_q    <= in_line_d;
            sof_pend_q   <= sof_pend_d;
            pack_q       <= pack_d;
            slot_q       <= slot_d;
            sample_cnt_q <= sample_cnt_d;
            line_cnt_q   <= line_cnt_d;
            skip_cnt_q   <= skip_cnt_d;
            wren_q       <= wren_d;
            data_q       <= data_d;
            sof_q        <= sof_d;
            eol_q        <= eol_d;
            frame_cnt_q  <= frame_cnt_d;
            line_err_q   <= line_err_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign ddr_wren        = wren_q;
    assign ddr_data_camera = data_q;
    assign ddr_sof         = sof_q;
    assign ddr_eol         = eol_q;
    assign frame_cnt       = frame_cnt_q;
    assign line_err        = line_err_q;
    assign frame_err       = frame_err_q;

endmodule

// File: tb/tb_camera_capture_pack.sv
// Directed bench for camera_capture_pack: instance A (8x4 frames, 2 skipped) and instance B (6-sample lines, no skip).
module tb_camera_capture_pack;

    logic        clk = 1'b0;
    logic        rst;
    logic        a_init, b_init;
    logic        capture_en;
    logic        href, vsync;
    logic [7:0]  data;

    logic        a_wren, a_sof, a_eol, a_line_err, a_frame_err;
    logic [31:0] a_data;
    logic [15:0] a_frame_cnt;
    logic        b_wren, b_sof, b_eol, b_line_err, b_frame_err;
    logic [31:0] b_data;
    logic [15:0] b_frame_cnt;

    int n_assert = 0;
    int n_fail   = 0;

    int          wr_cnt, sof_cnt, sof_first, eol_cnt, lerr_cnt, lerr_bad, ferr_cnt;
    logic [31:0] words [16];

    always #5 clk = ~clk;

    camera_capture_pack #(.DATA_W(8), .BYTES_PER_WORD(4), .H_BYTES(8), .V_LINES(4), .SKIP_FRAMES(2)) u_a (
        .camera_pclk(clk), .rst(rst), .init_done(a_init), .capture_en(capture_en),
        .camera_href(href), .camera_vsync(vsync), .camera_data(data),
        .ddr_wren(a_wren), .ddr_data_camera(a_data), .ddr_sof(a_sof), .ddr_eol(a_eol),
        .frame_cnt(a_frame_cnt), .line_err(a_line_err), .frame_err(a_frame_err)
    );

    camera_capture_pack #(.DATA_W(8), .BYTES_PER_WORD(4), .H_BYTES(6), .V_LINES(4), .SKIP_FRAMES(0)) u_b (
        .camera_pclk(clk), .rst(rst), .init_done(b_init), .capture_en(capture_en),
        .camera_href(href), .camera_vsync(vsync), .camera_data(data),
        .ddr_wren(b_wren), .ddr_data_camera(b_data), .ddr_sof(b_sof), .ddr_eol(b_eol),
        .frame_cnt(b_frame_cnt), .line_err(b_line_err), .frame_err(b_frame_err)
    );

    // Expected words are written MS-first; the LS-first build is the byte reversal of that.
    function automatic logic [31:0] swap_exp(input logic [31:0] w);
`ifdef CAPTURE_BYTE_SWAP_EN
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
        return w;
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_counts();
        wr_cnt = 0; sof_cnt = 0; sof_first = 0; eol_cnt = 0;
        lerr_cnt = 0; lerr_bad = 0; ferr_cnt = 0;
        for (int i = 0; i < 16; i++) words[i] = '0;
    endtask

    // One clock; outputs are sampled 1 ns after the edge and instance A's activity is tallied.
    task automatic tick();
        @(posedge clk);
        #1;
        if (a_wren) begin
            if (wr_cnt < 16) words[wr_cnt] = a_data;
            if (a_sof && wr_cnt == 0) sof_first++;
            wr_cnt++;
        end
        if (a_sof) sof_cnt++;
        if (a_eol) eol_cnt++;
        if (a_line_err) begin
            lerr_cnt++;
            if (!a_eol) lerr_bad++;
        end
        if (a_frame_err) ferr_cnt++;
    endtask

    task automatic send_frame(input int nlines, input int nbytes, input int first_len,
                              input int base, input int drop_line);
        int k;
        int len;
        k = base;
        vsync = 1'b1; repeat (3) tick();
        vsync = 1'b0; repeat (2) tick();
        for (int l = 0; l < nlines; l++) begin
            len  = (l == 0) ? first_len : nbytes;
            href = 1'b1;
            for (int i = 0; i < len; i++) begin
                data = 8'(k);
                k++;
                tick();
            end
            href = 1'b0;
            data = 8'h00;
            repeat (3) tick();
            if (l == drop_line) capture_en = 1'b0;
        end
        vsync = 1'b1;
        tick();
    endtask

    initial begin
        rst = 1'b1; a_init = 1'b0; b_init = 1'b0; capture_en = 1'b1;
        href = 1'b0; vsync = 1'b1; data = 8'h00;
        clear_counts();
        repeat (3) tick();
        rst = 1'b0;
        tick();

        check("reset_wren",      32'(a_wren),      32'h0);
        check("reset_data",      a_data,           32'h0);
        check("reset_sof",       32'(a_sof),       32'h0);
        check("reset_eol",       32'(a_eol),       32'h0);
        check("reset_frame_cnt", 32'(a_frame_cnt), 32'h0);
        check("reset_line_err",  32'(a_line_err),  32'h0);
        check("reset_frame_err", 32'(a_frame_err), 32'h0);

        // Instance B: 6-sample line with partial flush at line end.
        b_init = 1'b1;
        repeat (3) tick();
        vsync = 1'b0; tick();
        tick();
        href = 1'b1;
        data = 8'hA0; tick();
        data = 8'hA1; tick();
        data = 8'hA2; tick();
        data = 8'hA3; tick();
        check("b_word0_wren", 32'(b_wren), 32'h1);
        check("b_word0_data", b_data, swap_exp(32'hA0A1A2A3));
        check("b_word0_sof",  32'(b_sof), 32'h1);
        data = 8'hA4; tick();
        check("b_idle_wren", 32'(b_wren), 32'h0);
        check("b_data_hold", b_data, swap_exp(32'hA0A1A2A3));
        data = 8'hA5; tick();
        href = 1'b0; data = 8'h00; tick();
        check("b_flush_wren",     32'(b_wren),     32'h1);
        check("b_flush_data",     b_data,          swap_exp(32'hA4A50000));
        check("b_flush_eol",      32'(b_eol),      32'h1);
        check("b_flush_line_err", 32'(b_line_err), 32'h0);
        check("b_flush_sof",      32'(b_sof),      32'h0);
        tick();
        check("b_eol_one_cycle",  32'(b_eol),      32'h0);
        vsync = 1'b1; tick();
        check("b_frame_cnt",      32'(b_frame_cnt), 32'h1);
        check("b_frame_err",      32'(b_frame_err), 32'h1);

        // Instance B: reset in the middle of a line.
        vsync = 1'b0; tick();
        tick();
        href = 1'b1;
        for (int i = 0; i < 4; i++) begin
            data = 8'(8'hB0 + i);
            tick();
        end
        check("b_pre_rst_wren", 32'(b_wren), 32'h1);
        check("b_pre_rst_data", b_data, swap_exp(32'hB0B1B2B3));
        rst = 1'b1; tick();
        check("b_rst_wren",      32'(b_wren),      32'h0);
        check("b_rst_data",      b_data,           32'h0);
        check("b_rst_sof",       32'(b_sof),       32'h0);
        check("b_rst_eol",       32'(b_eol),       32'h0);
        check("b_rst_frame_cnt", 32'(b_frame_cnt), 32'h0);
        rst = 1'b0; b_init = 1'b0; href = 1'b0; data = 8'h00; vsync = 1'b1;
        repeat (2) tick();

        // Instance A: two skipped frames, then one captured 8x4 frame.
        a_init = 1'b1;
        tick();
        clear_counts();
        send_frame(4, 8, 8, 8'h00, -1);
        send_frame(4, 8, 8, 8'h00, -1);
        check("skip_no_wren",      32'(wr_cnt),      32'd0);
        check("skip_no_eol",       32'(eol_cnt),     32'd0);
        check("skip_frame_cnt",    32'(a_frame_cnt), 32'd0);
        clear_counts();
        send_frame(4, 8, 8, 8'h00, -1);
        check("f3_words",     32'(wr_cnt),      32'd8);
        check("f3_eols",      32'(eol_cnt),     32'd4);
        check("f3_sof_cnt",   32'(sof_cnt),     32'd1);
        check("f3_sof_first", 32'(sof_first),   32'd1);
        check("f3_word0",     words[0],         swap_exp(32'h00010203));
        check("f3_word1",     words[1],         swap_exp(32'h04050607));
        check("f3_word7",     words[7],         swap_exp(32'h1C1D1E1F));
        check("f3_line_errs", 32'(lerr_cnt),    32'd0);
        check("f3_frame_err", 32'(a_frame_err), 32'h0);
        check("f3_frame_cnt", 32'(a_frame_cnt), 32'd1);

        // Short first line and too few lines.
        clear_counts();
        send_frame(3, 8, 5, 8'h40, -1);
        check("f4_frame_err",   32'(a_frame_err), 32'h1);
        check("f4_frame_cnt",   32'(a_frame_cnt), 32'd2);
        check("f4_words",       32'(wr_cnt),      32'd6);
        check("f4_eols",        32'(eol_cnt),     32'd3);
        check("f4_line_errs",   32'(lerr_cnt),    32'd1);
        check("f4_lerr_no_eol", 32'(lerr_bad),    32'd0);
        check("f4_word0",       words[0],         swap_exp(32'h40414243));
        check("f4_word1_flush", words[1],         swap_exp(32'h44000000));
        check("f4_word2",       words[2],         swap_exp(32'h45464748));
        check("f4_sof_first",   32'(sof_first),   32'd1);
        tick();
        check("f4_frame_err_pulse", 32'(a_frame_err), 32'h0);

        // capture_en dropped after the first line: frame finishes, next one is ignored.
        clear_counts();
        send_frame(4, 8, 8, 8'h80, 0);
        check("f5_words",     32'(wr_cnt),      32'd8);
        check("f5_frame_cnt", 32'(a_frame_cnt), 32'd3);
        clear_counts();
        send_frame(4, 8, 8, 8'h00, -1);
        check("f6_no_words",  32'(wr_cnt),      32'd0);
        check("f6_no_eol",    32'(eol_cnt),     32'd0);
        check("f6_frame_cnt", 32'(a_frame_cnt), 32'd3);
        capture_en = 1'b1;
        clear_counts();
        send_frame(4, 8, 8, 8'h00, -1);
        check("f7_words",     32'(wr_cnt),      32'd8);
        check("f7_sof_first", 32'(sof_first),   32'd1);
        check("f7_word0",     words[0],         swap_exp(32'h00010203));
        check("f7_frame_cnt", 32'(a_frame_cnt), 32'd4);

        // init_done dropped after two samples of a word.
        clear_counts();
        vsync = 1'b1; repeat (2) tick();
        vsync = 1'b0; repeat (2) tick();
        href = 1'b1;
        data = 8'h11; tick();
        data = 8'h22; tick();
        a_init = 1'b0; href = 1'b0; data = 8'h00;
        tick();
        check("init_drop_wren", 32'(a_wren), 32'h0);
        check("init_drop_eol",  32'(a_eol),  32'h0);
        repeat (3) tick();
        check("init_drop_state_idle", 32'(u_a.state_q), 32'h0);
        check("init_drop_no_words",   32'(wr_cnt),      32'd0);
        check("init_drop_no_eols",    32'(eol_cnt),     32'd0);
        check("init_drop_frame_cnt",  32'(a_frame_cnt), 32'd4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/camera_capture_pack.md
Name: camera_capture_pack

Overview:
Parametrised DVP camera capture and word packer, successor to the fixed 8-bit/32-bit capture block. Samples the camera byte stream on camera_pclk, packs DATA_W-bit samples into words of BYTES_PER_WORD samples, and presents them to the DDR write path with start-of-frame and end-of-line markers. Adds frame-synchronised start/stop, startup frame skipping, partial-word flush at line end, and line/frame geometry checking.

Parameters:
DATA_W, 8, camera data bus width in bits
BYTES_PER_WORD, 4, samples packed per output word (2..8); WORD_W = DATA_W*BYTES_PER_WORD
H_BYTES, 1280, expected samples per line (href-high cycles)
V_LINES, 720, expected lines per frame
SKIP_FRAMES, 10, complete frames discarded after init_done before the first capture (0 = none)

Ports:
camera_pclk  in  1  sole clock; all logic on rising edge
rst  in  1  synchronous reset, active-high
init_done  in  1  sensor configuration complete
capture_en  in  1  capture request; honoured only at frame boundaries
camera_href  in  1  line valid
camera_vsync  in  1  frame sync, active-high during blanking
camera_data  in  DATA_W  pixel sample
ddr_wren  out  1  one-cycle write strobe
ddr_data_camera  out  WORD_W  packed word
ddr_sof  out  1  high with the first ddr_wren of a frame
ddr_eol  out  1  one-cycle end-of-line pulse
frame_cnt  out  16  completed captured frames, wraps 65535->0
line_err  out  1  one-cycle pulse: line length != H_BYTES
frame_err  out  1  one-cycle pulse: line count != V_LINES

Behaviour:
- Reset: all outputs 0; FSM to IDLE; pack register, sample counter, line counter, skip counter cleared.
- Valid sample: camera_href=1 and camera_vsync=0 sampled on a rising edge.
- FSM:
  IDLE: wait init_done=1 -> SKIP (SKIP_FRAMES>0) or ARM.
  SKIP: count vsync rising edges; after SKIP_FRAMES -> ARM. No outputs.
  ARM: on vsync falling edge with capture_en=1 -> CAPTURE; set sof_pending.
  CAPTURE: pack and emit; on vsync rising edge (frame end) -> ARM if capture_en=1, else IDLE-wait (ARM without re-arm until capture_en=1).
  init_done=0 in any state -> IDLE next cycle; partial word discarded, no flush, no pulses.
- Packing: first sample of a word occupies the MS bits (shift-left); the word is complete on the BYTES_PER_WORD-th sample.
- Latency: ddr_wren=1 and ddr_data_camera valid for exactly the cycle after the edge that sampled the last sample of the word; ddr_data_camera holds its value otherwise.
- Line end: detected on the edge where href is sampled 0 having been 1 (or vsync rises while href=1). That cycle: ddr_eol=1; if a partial word is pending, it is emitted with ddr_wren=1, unfilled low samples zero. Sample counter resets; a new line may start on the very next edge.
- ddr_sof: ANDed with the first ddr_wren after entering CAPTURE; sof_pending is then cleared.
- Geometry: samples per line counted (saturating at 2^16-1); at line end, count != H_BYTES -> line_err pulse coincident with ddr_eol. Lines counted per frame; at frame end, count != V_LINES -> frame_err pulse; frame_cnt increments on the same edge regardless.
- capture_en=0 mid-frame: current frame completes normally; no new frame starts.
- Outputs are pulses only in CAPTURE; ARM/SKIP/IDLE drive ddr_wren, ddr_eol, ddr_sof, and the error outputs to 0.

Optional Feature:
CAPTURE_BYTE_SWAP_EN: when defined, the first sample of each word occupies the LS bits (little-endian pack), and a flushed partial word is zero-padded in the high samples. When undefined, MS-first packing as above.

Test Plan:
- Reset, init_done=1, SKIP_FRAMES=2, capture_en=1, 8x4 frame of bytes 0x00.. -> no output for 2 frames; third frame first word 0x00010203 with ddr_sof=1, 8 words, 4 ddr_eol, frame_cnt=1, no errors.
- Line of 6 bytes A0..A5 (H_BYTES=6) -> words 0xA0A1A2A3 then 0xA4A50000 in the href-fall cycle with ddr_eol=1, line_err=0.
- Line of 5 bytes with H_BYTES=8 -> line_err=1 coincident with ddr_eol; 3 lines with V_LINES=4 -> frame_err=1 at vsync rise.
- capture_en dropped mid-frame -> frame completes, frame_cnt increments once, next frame produces no ddr_wren; re-raise -> capture resumes at next vsync fall with ddr_sof.
- init_done dropped after 2 bytes of a word -> no flush, no ddr_eol, FSM IDLE; rst asserted mid-line -> all outputs 0 next cycle.
- With CAPTURE_BYTE_SWAP_EN defined, bytes 01 02 03 04 -> 0x04030201; 2-byte line 05 06 -> 0x00000605.
